// File: rtl/muldiv_unit.sv
// Iterative multiply/divide unit with HI/LO registers: radix-2 shift-add multiply,
// restoring divide on operand magnitudes, sign fix-up in a final cycle.
module muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_FIX  = 2'd2;

  logic [1:0]         state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   opnd_q, opnd_d;
  logic               is_div_q, is_div_d;
  logic               neg_q, neg_d;
  logic               rem_neg_q, rem_neg_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic               done_q, done_d;
  logic               dbz_q, dbz_d;

  logic               signed_op, a_neg, b_neg;
  logic [WIDTH-1:0]   a_mag, b_mag;
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     div_rem_ext;
  logic               div_ge;
  logic [WIDTH-1:0]   div_diff;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quot_fix, rem_fix;

  // op 0 (mult) and op 2 (div) are the signed variants
  assign signed_op = ~op[0];
  assign a_neg     = signed_op & a[WIDTH-1];
  assign b_neg     = signed_op & b[WIDTH-1];
  assign a_mag     = a_neg ? -a : a;
  assign b_mag     = b_neg ? -b : b;

  // Multiply: acc = {partial sum, remaining multiplier bits}; add then shift right.
  assign mul_sum = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opnd_q} : '0);

  // Divide: acc = {partial remainder, remaining dividend / quotient bits}; shift left then trial-subtract.
  // The remainder after a successful subtract is below the divisor, so W bits of the difference suffice.
  assign div_rem_ext = acc_q[2*WIDTH-1:WIDTH-1];
  assign div_ge      = div_rem_ext >= {1'b0, opnd_q};
  assign div_diff    = acc_q[2*WIDTH-2:WIDTH-1] - opnd_q;

  assign prod_fix = neg_q ? -acc_q : acc_q;
  assign quot_fix = neg_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
  assign rem_fix  = rem_neg_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    opnd_d    = opnd_q;
    is_div_d  = is_div_q;
    neg_d     = neg_q;
    rem_neg_d = rem_neg_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    done_d    = 1'b0;
    dbz_d     = dbz_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          case (op)
            3'd0, 3'd1, 3'd2, 3'd3: begin
              is_div_d  = op[1];
              neg_d     = a_neg ^ b_neg;
              rem_neg_d = a_neg;
              if (op[1]) begin
                acc_d  = {{WIDTH{1'b0}}, a_mag};
                opnd_d = b_mag;
              end else begin
                acc_d  = {{WIDTH{1'b0}}, b_mag};
                opnd_d = a_mag;
              end
              cnt_d   = '0;
              dbz_d   = 1'b0;
              state_d = S_RUN;
            end
            3'd4: begin
              hi_d   = a;
              dbz_d  = 1'b0;
              done_d = 1'b1;
            end
            3'd5: begin
              lo_d   = a;
              dbz_d  = 1'b0;
              done_d = 1'b1;
            end
            default: ;
          endcase
        end
      end

      S_RUN: begin
        if (is_div_q) begin
          acc_d = div_ge ? {div_diff, acc_q[WIDTH-2:0], 1'b1}
                         : {acc_q[2*WIDTH-2:0], 1'b0};
        end else begin
          acc_d = {mul_sum, acc_q[WIDTH-1:1]};
        end
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CNT_LAST) state_d = S_FIX;
      end

      S_FIX: begin
        if (is_div_q) begin
          hi_d  = rem_fix;
          lo_d  = quot_fix;
          dbz_d = (opnd_q == '0);
        end else begin
          hi_d  = prod_fix[2*WIDTH-1:WIDTH];
          lo_d  = prod_fix[WIDTH-1:0];
          dbz_d = 1'b0;
        end
        done_d  = 1'b1;
        state_d = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      acc_q     <= '0;
      opnd_q    <= '0;
      is_div_q  <= 1'b0;
      neg_q     <= 1'b0;
      rem_neg_q <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
      done_q    <= 1'b0;
      dbz_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      opnd_q    <= opnd_d;
      is_div_q  <= is_div_d;
      neg_q     <= neg_d;
      rem_neg_q <= rem_neg_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      done_q    <= done_d;
      dbz_q     <= dbz_d;
    end
  end

  assign busy        = (state_q != S_IDLE);
  assign done        = done_q;
  assign div_by_zero = dbz_q;
  assign hi          = hi_q;
  assign lo          = lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: WIDTH=32 instance driven with directed and random ops,
// plus a WIDTH=8 instance for the narrow-width latency and result checks.
module tb_muldiv_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [2:0]  op;
  logic [31:0] a, b;
  logic        busy, done, dbz;
  logic [31:0] hi, lo;

  logic        start8;
  logic [2:0]  op8;
  logic [7:0]  a8, b8;
  logic        busy8, done8, dbz8;
  logic [7:0]  hi8, lo8;

  muldiv_unit #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b),
    .busy(busy), .done(done), .div_by_zero(dbz), .hi(hi), .lo(lo)
  );

  muldiv_unit #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .op(op8), .a(a8), .b(b8),
    .busy(busy8), .done(done8), .div_by_zero(dbz8), .hi(hi8), .lo(lo8)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dbz;
    int          start_cyc;
    int          lat;
  } exp_t;

  exp_t sb_q[$];

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] m_hi = '0;
  logic [31:0] m_lo = '0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Reference results: {div_by_zero, hi, lo}
  function automatic logic [64:0] model32(input logic [2:0] o, input logic [31:0] x, y,
                                          input logic [31:0] cur_hi, cur_lo);
    longint          sp;
    longint unsigned up;
    int              sx, sy, q, r;
    case (o)
      3'd0: begin
        sp = longint'($signed(x)) * longint'($signed(y));
        return {1'b0, sp[63:0]};
      end
      3'd1: begin
        up = 64'(x) * 64'(y);
        return {1'b0, up[63:0]};
      end
      3'd2: begin
        if (y == 32'd0) return {1'b1, x, (x[31] ? 32'd1 : 32'hFFFF_FFFF)};
        if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return {1'b0, 32'd0, 32'h8000_0000};
        sx = $signed(x);
        sy = $signed(y);
        q  = sx / sy;
        r  = sx % sy;
        return {1'b0, 32'(r), 32'(q)};
      end
      3'd3: begin
        if (y == 32'd0) return {1'b1, x, 32'hFFFF_FFFF};
        return {1'b0, x % y, x / y};
      end
      3'd4:    return {1'b0, x, cur_lo};
      3'd5:    return {1'b0, cur_hi, x};
      default: return {1'b0, cur_hi, cur_lo};
    endcase
  endfunction

  always @(negedge clk) begin
    if (!rst && done) begin
      if (sb_q.size() == 0) begin
        check_eq("spurious_done", 64'd1, 64'd0);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        check_eq("hi", hi, e.hi);
        check_eq("lo", lo, e.lo);
        check_eq("div_by_zero", dbz, e.dbz);
        check_eq("done_latency", 64'(cyc - e.start_cyc), 64'(e.lat));
      end
    end
  end

  // Issues one op (start may land in the same cycle as the previous done) and waits for its done.
  task automatic run_op(input logic [2:0] o, input logic [31:0] x, y, input bit poke);
    logic [64:0] r;
    logic [31:0] prev_hi, prev_lo;
    exp_t        e;
    int          busy_cnt;
    bit          seen;
    r       = model32(o, x, y, m_hi, m_lo);
    prev_hi = m_hi;
    prev_lo = m_lo;
    m_hi    = r[63:32];
    m_lo    = r[31:0];
    e.hi        = r[63:32];
    e.lo        = r[31:0];
    e.dbz       = r[64];
    e.start_cyc = cyc + 1;
    e.lat       = (o < 3'd4) ? 33 : 0;
    sb_q.push_back(e);
    start = 1'b1; op = o; a = x; b = y;
    @(negedge clk);
    start = 1'b0;
    busy_cnt = 0;
    seen     = 1'b0;
    for (int i = 0; i < 100 && !seen; i++) begin
      if (busy) busy_cnt++;
      if (done) begin
        seen = 1'b1;
      end else begin
        if (i == 5) begin
          check_eq("hold_hi", hi, prev_hi);
          check_eq("hold_lo", lo, prev_lo);
        end
        if (poke && i == 3) begin
          start = 1'b1; op = 3'd1; a = $urandom; b = $urandom;
        end else begin
          start = 1'b0;
        end
        @(negedge clk);
      end
    end
    start = 1'b0;
    if (!seen) check_eq("done_timeout", 64'd0, 64'd1);
    else       check_eq("busy_cycles", 64'(busy_cnt), (o < 3'd4) ? 64'd33 : 64'd0);
  endtask

  task automatic run8(input logic [2:0] o, input logic [7:0] x, y, input logic [7:0] ehi, elo);
    int n  = -1;
    int bc = 0;
    start8 = 1'b1; op8 = o; a8 = x; b8 = y;
    @(negedge clk);
    start8 = 1'b0;
    for (int i = 0; i < 40 && n < 0; i++) begin
      if (busy8) bc++;
      if (done8) n = i;
      else @(negedge clk);
    end
    if (n < 0) begin
      check_eq("w8_timeout", 64'd0, 64'd1);
    end else begin
      check_eq("w8_latency", 64'(n), 64'd9);
      check_eq("w8_busy_cycles", 64'(bc), 64'd9);
      check_eq("w8_hi", hi8, ehi);
      check_eq("w8_lo", lo8, elo);
      check_eq("w8_dbz", dbz8, 1'b0);
    end
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; op = '0; a = '0; b = '0;
    start8 = 1'b0; op8 = '0; a8 = '0; b8 = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    check_eq("rst_busy", busy, 1'b0);
    check_eq("rst_done", done, 1'b0);
    check_eq("rst_dbz", dbz, 1'b0);
    check_eq("rst_hi", hi, 32'd0);
    check_eq("rst_lo", lo, 32'd0);
    @(negedge clk);

    run_op(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    run_op(3'd0, -32'sd7, 32'd3, 1'b1);
    run_op(3'd2, -32'sd7, 32'd2, 1'b0);
    run_op(3'd3, 32'd100, 32'd0, 1'b0);
    run_op(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    run_op(3'd2, -32'sd9, 32'd0, 1'b0);
    run_op(3'd5, 32'h0000_1234, 32'd0, 1'b0);
    run_op(3'd4, 32'hCAFE_F00D, 32'd0, 1'b0);

    // Reserved op: no state change, no done
    start = 1'b1; op = 3'd6; a = 32'hDEAD_BEEF; b = 32'd5;
    @(negedge clk);
    start = 1'b0;
    check_eq("rsvd_busy", busy, 1'b0);
    repeat (3) @(negedge clk);
    check_eq("rsvd_hi", hi, m_hi);
    check_eq("rsvd_lo", lo, m_lo);

    for (int k = 0; k < 16; k++) begin
      logic [31:0] x, y;
      x = $urandom;
      case (k % 4)
        0:       y = 32'd0;
        1:       y = 32'($urandom_range(1, 15));
        2:       y = -32'($urandom_range(1, 15));
        default: y = $urandom;
      endcase
      run_op(3'($urandom_range(0, 3)), x, y, 1'b0);
    end

    // Reset in the middle of a divide discards the result
    start = 1'b1; op = 3'd2; a = 32'd12345; b = 32'd7;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_eq("midrst_busy", busy, 1'b0);
    check_eq("midrst_done", done, 1'b0);
    check_eq("midrst_hi", hi, 32'd0);
    check_eq("midrst_lo", lo, 32'd0);
    m_hi = '0;
    m_lo = '0;
    repeat (40) @(negedge clk);
    check_eq("midrst_still_idle", busy, 1'b0);

    run_op(3'd3, 32'd1000, 32'd7, 1'b0);

    run8(3'd0, 8'hF9, 8'h03, 8'hFF, 8'hEB);
    run8(3'd2, 8'hF9, 8'h02, 8'hFF, 8'hFD);

    repeat (5) @(negedge clk);
    check_eq("scoreboard_empty", 64'(sb_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
- Parametrised iterative multiply/divide unit that extends the single-cycle ALU with a HI/LO register pair.
- Executes mult, multu, div, divu, mthi and mtlo.
- Sits beside the ALU in the execute stage. The control unit stalls instruction fetch while busy=1.
- The HI/LO values feed the writeback mux for mfhi/mflo.

Parameters:
- WIDTH, 32: operand and HI/LO width in bits. Legal values are even and 4 or greater.

Ports:
- clk  input  1  clock; all state changes on the rising edge.
- rst  input  1  synchronous reset, active-high.
- start  input  1  request; sampled only while busy=0.
- op  input  3  operation: 0 mult, 1 multu, 2 div, 3 divu, 4 mthi, 5 mtlo; 6 and 7 reserved.
- a  input  WIDTH  rs operand: multiplicand, dividend, or mthi/mtlo source.
- b  input  WIDTH  rt operand: multiplier or divisor.
- busy  output  1  operation in progress; new starts are ignored.
- done  output  1  one-cycle pulse when HI/LO have been updated.
- div_by_zero  output  1  sticky flag for the last div/divu; valid when done=1.
- hi  output  WIDTH  HI register: product high half, or remainder.
- lo  output  WIDTH  LO register: product low half, or quotient.

Behaviour:
- Reset: when rst=1 at an edge, all registers clear regardless of state, including mid-operation.
  - The state returns to IDLE.
  - busy=0, done=0, div_by_zero=0, hi=0, lo=0, iteration counter=0.
  - An in-flight result is discarded.
- States and transitions:
  - IDLE -> RUN on start=1 with op 0–3.
  - RUN -> FIX after WIDTH iterations.
  - FIX -> IDLE, always.
  - IDLE -> IDLE on start with op 4/5, or with op 6/7.
- Start edge (edge 0), op 0–3:
  - Capture a and b.
  - For signed ops, store the operand signs and convert the operands to magnitudes using two's-complement negation.
  - Clear the accumulator and counter. Set busy=1.
- RUN, edges 1..WIDTH: one radix-2 step per edge, counter increments.
  - Multiply: shift-add over a 2*WIDTH-bit accumulator.
  - Divide: restoring shift-subtract, producing one quotient bit per edge.
- FIX, edge WIDTH+1:
  - Apply the sign correction.
  - Write hi/lo, set busy=0, and set done=1 for exactly one cycle.
  - Result latency: done is high in the cycle that begins WIDTH+1 edges after the start edge (33 for WIDTH=32).
- Sign rules:
  - Product is negated when the operand signs differ.
  - Quotient is negated when the operand signs differ.
  - Remainder takes the sign of the dividend.
  - Unsigned ops skip the correction.
- Divide by zero: no trap; the result falls out of restoring division on magnitudes.
  - divu: hi=a, lo=all ones.
  - div: hi=a; lo=1 if a<0, otherwise all ones.
  - div_by_zero=1 when done pulses. The flag is cleared on the next accepted start of any op.
- Signed overflow (a = most-negative, b = -1): lo = most-negative, hi = 0. No flag.
- mthi/mtlo: hi or lo is written with a at the start edge, and done pulses the following cycle. busy stays 0 and div_by_zero clears.
- Reserved ops: ignored. No state change, no done.
- start while busy=1: ignored. Operands, op and state are unaffected, and no error is raised.
- start in the same cycle that done=1: accepted, because busy is already 0. A back-to-back start is legal, and the previous hi/lo stay visible until its own FIX.
- hi/lo hold their values through RUN and change only at FIX, at an mthi/mtlo edge, or at reset.
- Multiple start pulses never queue; the unit has no buffer.

Test Plan:
- WIDTH=32, rst high for 2 cycles, then multu with a=0xFFFFFFFF, b=0xFFFFFFFF.
  - busy=1 for 33 cycles; done pulses exactly once at cycle 33 after the start edge.
  - Required result: hi=0xFFFFFFFE, lo=0x00000001.
- mult with a=-7, b=3 -> hi=0xFFFFFFFF, lo=0xFFFFFFEB.
- div with a=-7, b=2 -> lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1).
- divu with a=100, b=0 -> hi=100, lo=0xFFFFFFFF, div_by_zero=1.
- div with a=0x80000000, b=0xFFFFFFFF -> lo=0x80000000, hi=0, div_by_zero=0.
- Edge cases:
  - A second start during RUN is ignored: the first result is unchanged and only one done pulse occurs.
  - mtlo with a=0x1234 -> lo=0x1234 next cycle and busy never asserts.
  - rst=1 at cycle 10 of a div -> busy=0, hi=lo=0 the next cycle, and no done.
  - Repeat mult -7×3 with WIDTH=8 -> hi=0xFF, lo=0xEB, done at cycle 9.
